// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_seq_pkg
// Brief  : Shared state type, op encodings and constants for the FPU sequencer
// Rev    : 1.0
// ============================================================================
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } seq_state_e;

    localparam logic [1:0]  OP_ADD  = 2'b00;
    localparam logic [1:0]  OP_SUB  = 2'b01;
    localparam logic [1:0]  OP_MUL  = 2'b10;
    localparam logic [1:0]  OP_DIV  = 2'b11;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage
`default_nettype wire

// File: rtl/fpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : fpu_cmd_fifo
// Brief  : Synchronous command FIFO, registered count, no fall-through
// Rev    : 1.0
// ============================================================================
module fpu_cmd_fifo
    import fpu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              w_push;
    logic              w_pop;

    // Full/empty come from the registered count, so a same-cycle pop never frees a slot early.
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign w_push = wr_en_i && !full_o;
    assign w_pop  = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fpu_cmd_sequencer
// Brief  : Queues FPU commands, issues them one at a time, returns tagged results
// Rev    : 1.0
// ============================================================================
module fpu_cmd_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_op,
    output logic             fpu_start,
    input  logic [31:0]      fpu_r,
    input  logic             fpu_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_timeout,
    output logic             busy
);

    localparam int FIFO_W = 66 + TAG_W;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [31:0]       fpu_a_q, fpu_b_q;
    logic [1:0]        fpu_op_q;
    logic [TAG_W-1:0]  res_tag_q;
    logic [31:0]       res_data_q;
    logic              res_timeout_q;
    logic [CNT_W-1:0]  tmo_cnt_q;

    logic [FIFO_W-1:0] w_fifo_wdata;
    logic [FIFO_W-1:0] w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_pop;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_load_res;
    logic              w_res_nan;
    logic              w_tmo_hit;

    assign w_fifo_wdata = {cmd_tag, cmd_op, cmd_a, cmd_b};

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cmd_valid),
        .wr_data_i (w_fifo_wdata),
        .rd_en_i   (w_pop),
        .rd_data_o (w_fifo_rdata),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .count_o   (w_fifo_count)
    );

    assign w_tmo_hit = (tmo_cnt_q >= TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A real completion is checked before the timeout, so it wins a same-cycle tie.
    always_comb begin
        state_d    = state_q;
        w_pop      = 1'b0;
        fpu_start  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_load_res = 1'b0;
        w_res_nan  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_start = 1'b1;
                w_cnt_clr = 1'b1;
                state_d   = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                w_cnt_inc = 1'b1;
                if (!fpu_done) begin
                    state_d = ST_WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_load_res = 1'b1;
                    w_res_nan  = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_WAIT_DONE: begin
                w_cnt_inc = 1'b1;
                if (fpu_done) begin
                    w_load_res = 1'b1;
                    state_d    = ST_HOLD;
                end else if (w_tmo_hit) begin
                    w_load_res = 1'b1;
                    w_res_nan  = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_op_q      <= '0;
            res_tag_q     <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            if (w_pop) begin
                fpu_b_q   <= w_fifo_rdata[31:0];
                fpu_a_q   <= w_fifo_rdata[63:32];
                fpu_op_q  <= w_fifo_rdata[65:64];
                res_tag_q <= w_fifo_rdata[FIFO_W-1:66];
            end
            if (w_cnt_clr) begin
                tmo_cnt_q <= '0;
            end else if (w_cnt_inc) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
            if (w_load_res) begin
                res_data_q    <= w_res_nan ? FP_QNAN : fpu_r;
                res_timeout_q <= w_res_nan;
            end
        end
    end

    assign cmd_ready   = !w_fifo_full;
    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_op      = fpu_op_q;
    assign res_valid   = (state_q == ST_HOLD);
    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign res_timeout = res_timeout_q;
    assign busy        = (state_q != ST_IDLE) || (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fpu_cmd_sequencer
// Brief  : Self-checking bench: vector table, directed corners, random traffic
// Rev    : 1.0
// ============================================================================
module tb_fpu_cmd_sequencer;
    import fpu_seq_pkg::*;

    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic [31:0] fpu_a, fpu_b, fpu_r;
    logic [1:0]  fpu_op;
    logic        fpu_start, fpu_done;
    logic        res_valid, res_ready, res_timeout, busy;
    logic [31:0] res_data;
    logic [3:0]  res_tag;

    fpu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
        .fpu_r(fpu_r), .fpu_done(fpu_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: each accepted command defines its own expected result.
    typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] op; } iss_t;
    typedef struct { logic [31:0] data; logic [3:0] tag; logic to; } res_t;

    iss_t        iss_q[$];
    res_t        exp_q[$];
    int          fd_q[$];
    logic [31:0] fr_q[$];
    logic [3:0]  got_tags[$];

    int          drv_d;
    logic [31:0] drv_r;
    int          outstanding = 0;
    bit          drv_done;

    logic        prev_start, prev_hold, prev_to;
    logic [31:0] prev_a, prev_b, prev_data;
    logic [1:0]  prev_op;
    logic [3:0]  prev_tag;

    // FPU model: done drops on start and rises D cycles later with the scripted R.
    int          fd_cur, fk;
    logic [31:0] fr_cur;
    logic        frun;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_done <= 1'b0;
            fpu_r    <= '0;
            frun     <= 1'b0;
            fk       <= 0;
        end else if (fpu_start) begin
            if (fd_q.size() != 0) begin
                fd_cur = fd_q.pop_front();
                fr_cur = fr_q.pop_front();
            end else begin
                fd_cur = NEVER;
                fr_cur = '0;
            end
            frun     <= 1'b1;
            fk       <= 1;
            fpu_done <= 1'b0;
        end else if (frun) begin
            if (fk >= fd_cur) begin
                fpu_done <= 1'b1;
                fpu_r    <= fr_cur;
                frun     <= 1'b0;
            end else begin
                fk <= fk + 1;
            end
        end
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0; prev_hold = 1'b0; prev_to = 1'b0;
            prev_a = '0; prev_b = '0; prev_op = '0; prev_data = '0; prev_tag = '0;
            outstanding = 0;
        end else begin
            chk("busy", 32'(busy), 32'(outstanding != 0 || iss_q.size() != 0));
            if (prev_hold) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_data", res_data, prev_data);
                chk("hold_tag", 32'(res_tag), 32'(prev_tag));
                chk("hold_to", 32'(res_timeout), 32'(prev_to));
            end
            if (fpu_start) begin
                chk("start_one_cycle", 32'(prev_start), 0);
                chk("start_while_busy", 32'(outstanding), 0);
                chk("start_has_cmd", 32'(iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    chk("issue_a", fpu_a, iss_q[0].a);
                    chk("issue_b", fpu_b, iss_q[0].b);
                    chk("issue_op", 32'(fpu_op), 32'(iss_q[0].op));
                    void'(iss_q.pop_front());
                end
                outstanding++;
            end else begin
                chk("opnd_a_stable", fpu_a, prev_a);
                chk("opnd_b_stable", fpu_b, prev_b);
                chk("opnd_op_stable", 32'(fpu_op), 32'(prev_op));
            end
            if (res_valid && res_ready) begin
                chk("res_has_exp", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("res_data", res_data, exp_q[0].data);
                    chk("res_tag", 32'(res_tag), 32'(exp_q[0].tag));
                    chk("res_timeout", 32'(res_timeout), 32'(exp_q[0].to));
                    void'(exp_q.pop_front());
                end
                got_tags.push_back(res_tag);
                outstanding--;
            end
            if (cmd_valid && cmd_ready) begin
                iss_q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
                exp_q.push_back('{data: (drv_d >= 64) ? FP_QNAN : drv_r, tag: cmd_tag, to: (drv_d >= 64)});
                fd_q.push_back(drv_d);
                fr_q.push_back(drv_r);
            end
            prev_start = fpu_start;
            prev_hold  = res_valid && !res_ready;
            prev_data  = res_data; prev_tag = res_tag; prev_to = res_timeout;
            prev_a = fpu_a; prev_b = fpu_b; prev_op = fpu_op;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the command.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [3:0] tag, input int d, input logic [31:0] r);
        bit acc = 1'b0;
        drv_d = d; drv_r = r;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("push_accept", 32'(acc), 1);
    endtask

    typedef struct {
        logic [31:0] a; logic [31:0] b; logic [1:0] op; logic [3:0] tag;
        int d; logic [31:0] r;
        logic [31:0] exp_data; logic [3:0] exp_tag; logic exp_to; int exp_lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int lat, nres, nst;
        tbl[0] = '{32'h3F800000, 32'h40000000, OP_ADD, 4'd5,  8,     32'h40400000, 32'h40400000, 4'd5,  1'b0, 10};
        tbl[1] = '{32'h40400000, 32'h3F800000, OP_SUB, 4'd3,  3,     32'h40000000, 32'h40000000, 4'd3,  1'b0, 5};
        tbl[2] = '{32'h40000000, 32'h40400000, OP_MUL, 4'd9,  1,     32'h40C00000, 32'h40C00000, 4'd9,  1'b0, 3};
        tbl[3] = '{32'h40C00000, 32'h40000000, OP_DIV, 4'd15, 20,    32'h40400000, 32'h40400000, 4'd15, 1'b0, 22};
        tbl[4] = '{32'h3F800000, 32'h3F800000, OP_ADD, 4'd7,  63,    32'h40000000, 32'h40000000, 4'd7,  1'b0, 65};
        tbl[5] = '{32'h3F800000, 32'h3F800000, OP_MUL, 4'd8,  64,    32'h3F800000, 32'h7FC00000, 4'd8,  1'b1, 65};
        tbl[6] = '{32'h00000000, 32'h00000000, OP_DIV, 4'd12, NEVER, 32'h00000000, 32'h7FC00000, 4'd12, 1'b1, 65};
        tbl[7] = '{32'h41200000, 32'h40A00000, OP_SUB, 4'd1,  2,     32'h40A00000, 32'h40A00000, 4'd1,  1'b0, 4};

        // Reset values, with a command offered during reset that must be ignored.
        rst = 1'b1; res_ready = 1'b0; drv_d = 1; drv_r = '0;
        cmd_valid = 1'b1; cmd_a = 32'hDEADBEEF; cmd_b = 32'h1; cmd_op = OP_DIV; cmd_tag = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_fpu_start", 32'(fpu_start), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_timeout", 32'(res_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_fpu_op", 32'(fpu_op), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_tag", 32'(res_tag), 0);
        cmd_valid = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_push_in_rst", 32'(busy), 0);

        // Single operations from the vector table, checking issue timing and result latency.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("tbl_cmd_ready", 32'(cmd_ready), 1);
            drv_d = tbl[i].d; drv_r = tbl[i].r;
            cmd_a = tbl[i].a; cmd_b = tbl[i].b; cmd_op = tbl[i].op; cmd_tag = tbl[i].tag;
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("tbl_start_c1", 32'(fpu_start), 0);
            @(negedge clk);
            chk("tbl_start_c2", 32'(fpu_start), 1);
            chk("tbl_fpu_a", fpu_a, tbl[i].a);
            lat = 0;
            for (int n = 1; n < 200; n++) begin
                @(negedge clk);
                if (res_valid) begin lat = n; break; end
            end
            chk("tbl_res_valid", 32'(res_valid), 1);
            chk("tbl_latency", 32'(lat), 32'(tbl[i].exp_lat));
            chk("tbl_data", res_data, tbl[i].exp_data);
            chk("tbl_tag", 32'(res_tag), 32'(tbl[i].exp_tag));
            chk("tbl_timeout", 32'(res_timeout), 32'(tbl[i].exp_to));
            @(posedge clk); #1 res_ready = 1'b1;
            @(posedge clk); #1 res_ready = 1'b0;
        end

        // FIFO full under result backpressure, then in-order drain.
        got_tags.delete();
        @(posedge clk); #1;
        push(32'h3F800000, 32'h3F800000, OP_ADD, 4'd0, 4, 32'h40000000);
        for (int t = 1; t < 5; t++) push(32'h40000000 + t, 32'h3F800000, OP_MUL, 4'(t), 2, 32'h41000000 + t);
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_tag = 4'd5; drv_d = 2; drv_r = 32'h1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("full_stays_full", 32'(cmd_ready), 0);
        end
        chk("bp_res_valid", 32'(res_valid), 1);
        chk("bp_res_tag", 32'(res_tag), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; res_ready = 1'b1;
        for (int n = 0; n < 300 && got_tags.size() < 5; n++) @(negedge clk);
        chk("drain_count", 32'(got_tags.size()), 5);
        for (int t = 0; t < 5 && t < got_tags.size(); t++) chk("drain_order", 32'(got_tags[t]), 32'(t));
        @(posedge clk); #1 res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a stalled operation with commands queued.
        push(32'h11111111, 32'h22222222, OP_ADD, 4'd1, NEVER, 32'h0);
        push(32'h33333333, 32'h44444444, OP_SUB, 4'd2, NEVER, 32'h0);
        push(32'h55555555, 32'h66666666, OP_MUL, 4'd3, NEVER, 32'h0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_fpu_start", 32'(fpu_start), 0);
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_fpu_a", fpu_a, 0);
        chk("mid_rst_fpu_op", 32'(fpu_op), 0);
        chk("mid_rst_res_tag", 32'(res_tag), 0);
        iss_q.delete(); exp_q.delete(); fd_q.delete(); fr_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; res_ready = 1'b1;
        nres = 0; nst = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (res_valid) nres++;
            if (fpu_start) nst++;
        end
        chk("post_rst_no_result", 32'(nres), 0);
        chk("post_rst_no_start", 32'(nst), 0);
        chk("post_rst_idle", 32'(busy), 0);

        // Random traffic against the scoreboard with random result backpressure.
        @(posedge clk); #1;
        res_ready = 1'b0; drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int r, d, g;
                    g = int'($urandom_range(0, 3));
                    repeat (g) begin @(posedge clk); #1; end
                    r = int'($urandom_range(0, 9));
                    if (r < 6)      d = int'($urandom_range(1, 12));
                    else if (r < 9) d = int'($urandom_range(61, 66));
                    else            d = NEVER;
                    push($urandom, $urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), d, $urandom);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        for (int n = 0; n < 5000 && (exp_q.size() != 0 || outstanding != 0); n++) @(negedge clk);
        chk("rand_drained", 32'(exp_q.size()), 0);
        chk("rand_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
`default_nettype wire
